// File: rtl/alu_fx_pkg.sv
// alu_fx_pkg: function codes and controller states shared by alu_fx and its multiplier
package opcodes;
  typedef enum logic [2:0] {ALU_A, ALU_ADD, ALU_SUB, ALU_MULT, ALU_MAC} alu_functions_t;
  typedef enum logic [1:0] {IDLE, MULT, DONE} alu_fx_state_t;
endpackage

// File: rtl/alu_fx_mult.sv
// alu_fx_mult: iterative unsigned radix-2 shift-add multiplier on N+1-bit magnitudes
module alu_fx_mult #(
  parameter int N = 8
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_load,
  input  logic           i_run,
  input  logic [N:0]     i_ma,
  input  logic [N:0]     i_mb,
  output logic [2*N+1:0] o_prod,
  output logic           o_last
);
  localparam int CW = $clog2(N);
  logic [2*N+1:0] r_p;
  logic [N:0]     r_ma;
  logic [CW-1:0]  r_cnt;
  logic [N+1:0]   w_sum;
  assign w_sum  = {1'b0, r_p[2*N+1:N+1]} + (r_p[0] ? {1'b0, r_ma} : '0);
  // o_prod is the register value after the current step; after N steps it holds twice the product
  assign o_prod = {w_sum, r_p[N:1]};
  assign o_last = r_cnt == CW'(N - 1);
  // load operands on acceptance, then one add-and-shift step per cycle while running
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_p   <= '0;
      r_ma  <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_p   <= {{(N+1){1'b0}}, i_mb};
      r_ma  <= i_ma;
      r_cnt <= '0;
    end else if (i_run) begin
      r_p   <= o_prod;
      r_cnt <= r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/alu_fx.sv
// alu_fx: multi-cycle signed fixed-point ALU with MAC accumulator; ALU_FX_SATURATE_EN enables clamping
module alu_fx
  import opcodes::*;
#(
  parameter int N    = 8,
  parameter int FRAC = N - 1
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_start,
  input  alu_functions_t i_func,
  input  logic [N-1:0]   i_a,
  input  logic [N-1:0]   i_b,
  input  logic           i_clear_acc,
  output logic           o_busy,
  output logic           o_done,
  output logic [N-1:0]   o_q,
  output logic [N-1:0]   o_acc
);
`ifdef ALU_FX_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  function automatic logic [N-1:0] fit(input logic [N:0] x);
    return (SAT && (x[N] ^ x[N-1])) ? {x[N], {(N-1){~x[N]}}} : x[N-1:0];
  endfunction
  alu_fx_state_t         r_state;
  logic                  r_busy, r_done, r_mac, r_neg;
  logic [N-1:0]          r_q, r_acc;
  logic [N:0]            w_ma, w_mb;
  logic [2*N+1:0]        w_prod;
  logic signed [2*N+1:0] w_full, w_sh;
  logic [N-1:0]          w_mres, w_base, w_mac, w_alu;
  logic                  w_last, w_mul_op, w_povf;
  // magnitudes, sign fixup, Q-format scaling and the single-cycle result
  always_comb begin
    w_ma     = i_a[N-1] ? -{1'b1, i_a} : {1'b0, i_a};
    w_mb     = i_b[N-1] ? -{1'b1, i_b} : {1'b0, i_b};
    w_full   = r_neg ? -w_prod : w_prod;
    w_sh     = w_full >>> (FRAC + 1);
    w_povf   = !((&w_sh[2*N+1:N-1]) || !(|w_sh[2*N+1:N-1]));
    w_mres   = (SAT && w_povf) ? {w_sh[2*N+1], {(N-1){~w_sh[2*N+1]}}} : w_sh[N-1:0];
    w_base   = i_clear_acc ? '0 : r_acc;
    w_mac    = fit({w_base[N-1], w_base} + {w_mres[N-1], w_mres});
    w_mul_op = (i_func == ALU_MULT) || (i_func == ALU_MAC);
    w_alu    = i_func == ALU_A   ? i_a :
               i_func == ALU_ADD ? fit({i_a[N-1], i_a} + {i_b[N-1], i_b}) :
               i_func == ALU_SUB ? fit({i_a[N-1], i_a} - {i_b[N-1], i_b}) : '0;
  end
  alu_fx_mult #(.N(N)) u_mult (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (r_state == IDLE && i_start && w_mul_op),
    .i_run  (r_state == MULT),
    .i_ma   (w_ma),
    .i_mb   (w_mb),
    .o_prod (w_prod),
    .o_last (w_last)
  );
  // controller: accept in IDLE, iterate in MULT, pulse done from DONE; clear_acc wins over stale acc
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_mac   <= 1'b0;
      r_neg   <= 1'b0;
      r_q     <= '0;
      r_acc   <= '0;
    end else begin
      r_done <= 1'b0;
      if (i_clear_acc) r_acc <= '0;
      case (r_state)
        IDLE: if (i_start) begin
          r_busy <= 1'b1;
          if (w_mul_op) begin
            r_mac   <= i_func == ALU_MAC;
            r_neg   <= i_a[N-1] ^ i_b[N-1];
            r_state <= MULT;
          end else begin
            r_q     <= w_alu;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        MULT: if (w_last) begin
          r_q     <= r_mac ? w_mac : w_mres;
          if (r_mac) r_acc <= w_mac;
          r_done  <= 1'b1;
          r_state <= DONE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end
  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_q    = r_q;
  assign o_acc  = r_acc;
endmodule

// File: tb/tb_alu_fx.sv
// tb_alu_fx: directed vector table plus hand-written handshake, clear and reset sequences for alu_fx
module tb_alu_fx;
  import opcodes::*;
`ifdef ALU_FX_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  alu_functions_t func = ALU_A;
  logic [7:0]     a = '0, b = '0;
  logic           clear_acc = 1'b0;
  logic           busy, done;
  logic [7:0]     q, acc;
  int             n_chk = 0, n_fail = 0;

  alu_fx #(.N(8), .FRAC(7)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_func(func), .i_a(a), .i_b(b),
    .i_clear_acc(clear_acc), .o_busy(busy), .o_done(done), .o_q(q), .o_acc(acc)
  );

  always #5 clk = ~clk;

  typedef struct {
    alu_functions_t f;
    logic [7:0]     a, b;
    logic           clr;
    logic [7:0]     q, acc;
    int             lat;
  } vec_t;
  vec_t tbl[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic issue(input alu_functions_t f, input logic [7:0] x, input logic [7:0] y, input logic clr);
    @(negedge clk);
    func = f; a = x; b = y; clear_acc = clr; start = 1'b1;
  endtask

  initial begin
    int ndone, dcyc, busy_ok;
    logic [7:0] cq, cacc;
    tbl[0]  = '{ALU_ADD,  8'h70, 8'h20, 1'b0, SAT ? 8'h7F : 8'h90, 8'h00, 1};
    tbl[1]  = '{ALU_SUB,  8'h10, 8'h30, 1'b0, 8'hE0, 8'h00, 1};
    tbl[2]  = '{ALU_SUB,  8'h80, 8'h01, 1'b0, SAT ? 8'h80 : 8'h7F, 8'h00, 1};
    tbl[3]  = '{ALU_A,    8'h5A, 8'h33, 1'b0, 8'h5A, 8'h00, 1};
    tbl[4]  = '{ALU_MULT, 8'h40, 8'h40, 1'b0, 8'h20, 8'h00, 9};
    tbl[5]  = '{ALU_MULT, 8'h80, 8'h80, 1'b0, SAT ? 8'h7F : 8'h80, 8'h00, 9};
    tbl[6]  = '{ALU_MULT, 8'hC0, 8'h40, 1'b0, 8'hE0, 8'h00, 9};
    tbl[7]  = '{ALU_MULT, 8'hFF, 8'h01, 1'b0, 8'hFF, 8'h00, 9};
    tbl[8]  = '{ALU_MULT, 8'h80, 8'h40, 1'b0, 8'hC0, 8'h00, 9};
    tbl[9]  = '{ALU_MAC,  8'h40, 8'h40, 1'b1, 8'h20, 8'h20, 9};
    tbl[10] = '{ALU_MAC,  8'h40, 8'h40, 1'b0, 8'h40, 8'h40, 9};
    tbl[11] = '{ALU_MAC,  8'h40, 8'h40, 1'b1, 8'h20, 8'h20, 9};
    tbl[12] = '{ALU_MAC,  8'h80, 8'h80, 1'b0, SAT ? 8'h7F : 8'hA0, SAT ? 8'h7F : 8'hA0, 9};
    tbl[13] = '{alu_functions_t'(3'd7), 8'h12, 8'h34, 1'b0, 8'h00, SAT ? 8'h7F : 8'hA0, 1};
    tbl[14] = '{ALU_ADD,  8'h90, 8'h90, 1'b0, SAT ? 8'h80 : 8'h20, SAT ? 8'h7F : 8'hA0, 1};

    repeat (2) @(negedge clk);
    check("reset busy", 32'(busy), 0);
    check("reset done", 32'(done), 0);
    check("reset q", 32'(q), 0);
    check("reset acc", 32'(acc), 0);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      issue(tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].clr);
      ndone = 0; dcyc = 0; busy_ok = 1; cq = '0; cacc = '0;
      for (int c = 1; c <= 12; c++) begin
        @(negedge clk);
        start = 1'b0; clear_acc = 1'b0;
        if (done) begin ndone++; dcyc = c; cq = q; cacc = acc; end
        if (busy !== (c <= tbl[i].lat)) busy_ok = 0;
      end
      check($sformatf("vec%0d q", i), 32'(cq), 32'(tbl[i].q));
      check($sformatf("vec%0d acc", i), 32'(cacc), 32'(tbl[i].acc));
      check($sformatf("vec%0d done cycle", i), 32'(dcyc), 32'(tbl[i].lat));
      check($sformatf("vec%0d done count", i), 32'(ndone), 1);
      check($sformatf("vec%0d busy window", i), 32'(busy_ok), 1);
    end

    issue(ALU_MULT, 8'h40, 8'h40, 1'b0);
    ndone = 0; dcyc = 0; cq = '0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (done) begin ndone++; dcyc = c; cq = q; end
      if (c == 12) check("ignored start busy", 32'(busy), 0);
      start = (c == 3);
      func = ALU_ADD; a = 8'h01; b = 8'h01;
    end
    start = 1'b0;
    check("ignored start done count", 32'(ndone), 1);
    check("ignored start done cycle", 32'(dcyc), 9);
    check("ignored start q", 32'(cq), 32'h20);

    issue(ALU_MAC, 8'h40, 8'h40, 1'b0);
    ndone = 0; cq = '0; cacc = '0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin ndone++; cq = q; cacc = acc; end
      if (c == 4) check("clear during mult acc", 32'(acc), 0);
      clear_acc = (c == 3);
    end
    clear_acc = 1'b0;
    check("clear during mult result acc", 32'(cacc), 32'h20);
    check("clear during mult result q", 32'(cq), 32'h20);
    check("clear during mult done count", 32'(ndone), 1);

    issue(ALU_MULT, 8'h40, 8'h40, 1'b0);
    ndone = 0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c >= 5 && done) ndone++;
      if (c == 5) begin
        check("reset mid-mult busy", 32'(busy), 0);
        check("reset mid-mult done", 32'(done), 0);
        check("reset mid-mult q", 32'(q), 0);
        check("reset mid-mult acc", 32'(acc), 0);
      end
      rst = (c == 4);
    end
    rst = 1'b0;
    check("reset mid-mult no done", 32'(ndone), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
